button_conditioner: RTL and testbench

//  Cleans raw Basys3 push-button inputs for the calculator mode FSM.
//  - Synchronises each button to clk and debounces it.
//  - Outputs a stable level plus one-cycle press/release pulses.
//  - Sits between the board pins and the mode FSM; btn_press[R]/[L] drive the FSM's advance/clear inputs.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 100 ++++++++++
 rtl/button_conditioner.sv | 31 +++
 tb/tb_button_conditioner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants: debounce state encoding, button indices, timing
package calc_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      CHECK_HIGH  = 2'd1,
      STABLE_HIGH = 2'd2,
      CHECK_LOW   = 2'd3
   } db_state_t;

   localparam int BTN_C = 0;
   localparam int BTN_U = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;
   localparam int BTN_D = 4;

   // 10 ms of stable input at 100 MHz
   localparam int DEBOUNCE_10MS = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debounce FSM and stability counter
module debounce_channel
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   db_state_t              state, state_d;
   logic [CW-1:0]          cnt, cnt_d;
   logic                   level_d, press_d, rel_d;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         state  <= STABLE_LOW;
         cnt    <= '0;
         level  <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         state  <= state_d;
         cnt    <= cnt_d;
         level  <= level_d;
         press  <= press_d;
         rel    <= rel_d;
      end
   end

   // cnt counts cycles the new value has been seen; accept once it has
   // already been seen DEBOUNCE_CYCLES times and is still present
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state)
         STABLE_LOW: begin
            if (sync) begin
               state_d = CHECK_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_HIGH: begin
            if (!sync) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt == CNT_MAX) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!sync) begin
               state_d = CHECK_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_LOW: begin
            if (sync) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt == CNT_MAX) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and press/release pulses for the board buttons
module button_conditioner
   import calc_pkg::*;
#(
   parameter int NUM_BTNS        = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release
);

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_chan (
         .clk  (clk),
         .reset(reset),
         .raw  (btn_raw[i]),
         .level(btn_level[i]),
         .press(btn_press[i]),
         .rel  (btn_release[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench against a run-length reference model
module tb_button_conditioner;

   localparam int N = 2;
   localparam int D = 4;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_press, btn_release;

   int errors = 0;
   int checks = 0;

   logic [N-1:0] pipe [S];
   int           run [N];
   logic [N-1:0] m_level, m_press, m_rel;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BTNS       (N),
      .DEBOUNCE_CYCLES(D),
      .SYNC_STAGES    (S)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   // A change is accepted once the value seen after S register delays has
   // differed from the accepted level for D+1 consecutive edges.
   task automatic model_edge(input logic [N-1:0] raw, input logic rst);
      logic [N-1:0] seen;
      m_press = '0;
      m_rel   = '0;
      if (rst) begin
         for (int i = 0; i < S; i++) pipe[i] = '0;
         for (int c = 0; c < N; c++) run[c] = 0;
         m_level = '0;
      end else begin
         seen = pipe[S-1];
         for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = raw;
         for (int c = 0; c < N; c++) begin
            if (seen[c] != m_level[c]) begin
               run[c] = run[c] + 1;
               if (run[c] == D + 1) begin
                  m_level[c] = seen[c];
                  if (seen[c]) m_press[c] = 1'b1;
                  else         m_rel[c]   = 1'b1;
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
         end
      end
   endtask

   task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic [N-1:0] raw, input logic rst);
      btn_raw = raw;
      reset   = rst;
      @(posedge clk);
      model_edge(raw, rst);
      #1;
      check_vec("level", btn_level, m_level);
      check_vec("press", btn_press, m_press);
      check_vec("release", btn_release, m_rel);
      check_vec("press_and_release", btn_press & btn_release, '0);
   endtask

   initial begin
      logic [N-1:0] r;
      for (int i = 0; i < S; i++) pipe[i] = '0;
      for (int c = 0; c < N; c++) run[c] = 0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      btn_raw = '0;
      reset   = 1'b1;

      for (int k = 0; k < 3; k++) step(2'b00, 1'b1);
      check_vec("reset_level", btn_level, 2'b00);

      // single press, accepted at edge 6
      for (int k = 0; k < 20; k++) begin
         step(2'b01, 1'b0);
         if (k == 5) check_vec("t1_no_early_press", btn_press, 2'b00);
         if (k == 6) check_vec("t1_press_edge6", btn_press, 2'b01);
         if (k == 6) check_vec("t1_level_edge6", btn_level, 2'b01);
      end

      // release, accepted at edge 6
      for (int k = 0; k < 20; k++) begin
         step(2'b00, 1'b0);
         if (k == 6) check_vec("t3_release_edge6", btn_release, 2'b01);
         if (k == 6) check_vec("t3_level_edge6", btn_level, 2'b00);
      end

      // short bounce is rejected
      for (int k = 0; k < 3; k++) step(2'b01, 1'b0);
      for (int k = 0; k < 10; k++) step(2'b00, 1'b0);
      check_vec("t2_level_after_bounce", btn_level, 2'b00);

      // simultaneous press on both channels, then glitches on channel 1 only
      for (int k = 0; k < 8; k++) begin
         step(2'b11, 1'b0);
         if (k == 6) check_vec("t4_press_both", btn_press, 2'b11);
      end
      for (int k = 0; k < 10; k++) step({k[0], 1'b1}, 1'b0);
      check_vec("t4_ch0_level_held", btn_level & 2'b01, 2'b01);
      for (int k = 0; k < 12; k++) step(2'b00, 1'b0);

      // reset mid-count, button still held
      for (int k = 0; k < 4; k++) step(2'b10, 1'b0);
      step(2'b10, 1'b1);
      for (int k = 0; k < 12; k++) begin
         step(2'b10, 1'b0);
         if (k == 6) check_vec("t5_press_after_reset", btn_press, 2'b10);
      end

      // long reset while idle
      for (int k = 0; k < 10; k++) step(2'b00, 1'b1);
      for (int k = 0; k < 10; k++) step(2'b00, 1'b0);
      check_vec("t6_level_idle", btn_level, 2'b00);

      // random bouncing stimulus with occasional resets
      r = '0;
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
         step(r, ($urandom_range(0, 149) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
